// File: rtl/mlite_acc_arbiter.sv
// Round-robin arbiter/sequencer sharing the mlite accumulate datapath among NREQ requesters.
// Optional MLITE_ACC_ARB_CLEAR_EN inserts a one-cycle datapath clear before every issue.
module mlite_acc_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 16,
  parameter int LAT  = 1
) (
  input  logic              clk,
  input  logic              reset_in,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [W-1:0]      rsp_data,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [W-1:0]      dp_din,
  output logic              dp_load,
  output logic              dp_clr,
  input  logic [W-1:0]      dp_dout
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, CLEAR, ISSUE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   gnt_q, gnt_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    op_q, op_d;
  logic [W-1:0]    rsp_data_q, rsp_data_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [W-1:0]    dp_din_q, dp_din_d;
  logic            dp_load_q, dp_load_d;
  logic            dp_clr_q, dp_clr_d;

  logic            win_found;
  logic [PW-1:0]   win_idx;
  logic [W-1:0]    win_data;

  // Scan starts at ptr and wraps, so the requester after the last one served has priority.
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_idx   = '0;
    win_data  = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_idx   = PW'(idx);
        win_data  = req_data[idx*W +: W];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && win_found && !reset_in) begin
      req_ready[win_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    rsp_data_d = rsp_data_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          op_d  = win_data;
          gnt_d = win_idx;
`ifdef MLITE_ACC_ARB_CLEAR_EN
          state_d = CLEAR;
`else
          state_d = ISSUE;
`endif
        end
      end
      CLEAR: state_d = ISSUE;
      ISSUE: begin
        cnt_d   = CW'(LAT - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rsp_data_d = dp_dout;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready[gnt_q]) begin
          ptr_d   = (gnt_q == PW'(NREQ - 1)) ? '0 : gnt_q + PW'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Strobes are decoded from the next state so they come straight out of flops.
    dp_load_d   = (state_d == ISSUE);
    dp_din_d    = dp_load_d ? op_d : '0;
    rsp_valid_d = (state_d == RESP) ? (ONE_HOT0 << gnt_d) : '0;
`ifdef MLITE_ACC_ARB_CLEAR_EN
    dp_clr_d    = (state_d == CLEAR);
`else
    dp_clr_d    = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      cnt_q       <= '0;
      op_q        <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= '0;
      dp_din_q    <= '0;
      dp_load_q   <= 1'b0;
      dp_clr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      dp_din_q    <= dp_din_d;
      dp_load_q   <= dp_load_d;
      dp_clr_q    <= dp_clr_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign dp_din    = dp_din_q;
  assign dp_load   = dp_load_q;
  assign dp_clr    = dp_clr_q;

endmodule

// File: tb/tb_mlite_acc_arbiter.sv
// Self-checking bench for mlite_acc_arbiter: transaction-timing reference model plus a datapath stub.
// Honours MLITE_ACC_ARB_CLEAR_EN the same way as the design.
module tb_mlite_acc_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 16;
  localparam int LAT  = 2;
`ifdef MLITE_ACC_ARB_CLEAR_EN
  localparam int C = 1;
`else
  localparam int C = 0;
`endif

  logic          clk;
  logic          reset_in;
  logic [3:0]    req_valid;
  logic [63:0]   req_data;
  logic [3:0]    req_ready;
  logic [3:0]    rsp_valid;
  logic [15:0]   rsp_data;
  logic [3:0]    rsp_ready;
  logic [15:0]   dp_din;
  logic          dp_load;
  logic          dp_clr;
  logic [15:0]   dp_dout;

  int checks   = 0;
  int failures = 0;

  // Reference model: elapsed cycles since the request handshake drive every expectation.
  int          m_busy;
  int          m_age;
  int          m_gnt;
  int          m_ptr;
  logic [15:0] m_op;
  logic [15:0] m_rdata;
  int          hs_last;

  mlite_acc_arbiter #(.NREQ(NREQ), .W(W), .LAT(LAT)) dut (
    .clk(clk), .reset_in(reset_in),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .dp_din(dp_din), .dp_load(dp_load), .dp_clr(dp_clr), .dp_dout(dp_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath stub: din+1 after a load, then drifts by 0x100 per cycle so late sampling shows up.
  always @(posedge clk) begin
    if (reset_in || dp_clr) dp_dout <= 16'h0000;
    else if (dp_load)       dp_dout <= dp_din + 16'h0001;
    else                    dp_dout <= dp_dout + 16'h0100;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int winner(input logic [3:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic modelReset();
    m_busy  = 0;
    m_age   = 0;
    m_gnt   = 0;
    m_ptr   = 0;
    m_op    = 16'h0000;
    m_rdata = 16'h0000;
    hs_last = -1;
  endtask

  task automatic checkOutput();
    logic [3:0]  e_ready;
    logic [3:0]  e_rv;
    logic        e_load;
    logic        e_clr;
    int          w;
    e_ready = 4'b0000;
    if (m_busy == 0 && !reset_in) begin
      w = winner(req_valid, m_ptr);
      if (w >= 0) e_ready[w] = 1'b1;
    end
    e_clr  = (m_busy != 0) && (C == 1) && (m_age == 1);
    e_load = (m_busy != 0) && (m_age == 1 + C);
    e_rv   = ((m_busy != 0) && (m_age >= LAT + 2 + C)) ? (4'b0001 << m_gnt) : 4'b0000;
    chk("req_ready", {28'd0, req_ready}, {28'd0, e_ready});
    chk("dp_clr",    {31'd0, dp_clr},    {31'd0, e_clr});
    chk("dp_load",   {31'd0, dp_load},   {31'd0, e_load});
    chk("dp_din",    {16'd0, dp_din},    {16'd0, (e_load ? m_op : 16'h0000)});
    chk("rsp_valid", {28'd0, rsp_valid}, {28'd0, e_rv});
    chk("rsp_data",  {16'd0, rsp_data},  {16'd0, m_rdata});
  endtask

  // Advance one clock; the model consumes the inputs that were stable across the edge.
  task automatic applyStimulus();
    int w;
    @(posedge clk);
    hs_last = -1;
    if (!reset_in) begin
      if (m_busy == 0) begin
        w = winner(req_valid, m_ptr);
        if (w >= 0) begin
          m_busy  = 1;
          m_age   = 1;
          m_gnt   = w;
          m_op    = req_data[w*16 +: 16];
          hs_last = w;
        end
      end else begin
        if (m_age == LAT + 1 + C) m_rdata = m_op + 16'h0001 + 16'(16'h0100 * (LAT - 1));
        if (m_age >= LAT + 2 + C && rsp_ready[m_gnt]) begin
          m_busy = 0;
          m_ptr  = (m_gnt + 1) % NREQ;
        end else if (m_age < 100000) begin
          m_age++;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_op(input logic [3:0] mask, input int hold, output int granted);
    int n;
    granted   = -1;
    req_valid = mask;
    rsp_ready = 4'b0000;
    for (int k = 0; k < 20 && m_busy == 0; k++) begin
      #1 checkOutput();
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) granted = i;
      applyStimulus();
    end
    if (m_busy == 0) chk("grant_timeout", 32'd0, 32'd1);
    n = 0;
    for (int k = 0; k < 40 && m_busy != 0; k++) begin
      if (m_age >= LAT + 2 + C) begin
        if (n >= hold) rsp_ready = 4'b1111;
        n++;
      end
      #1 checkOutput();
      applyStimulus();
    end
    rsp_ready = 4'b0000;
  endtask

  task automatic pulseReset();
    #3 reset_in = 1'b1;
    modelReset();
    #1 checkOutput();
    @(posedge clk);
    @(negedge clk);
    reset_in = 1'b0;
  endtask

  task automatic randomizeInputs();
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && hs_last != i) begin
        if ($urandom_range(0, 9) == 0) req_valid[i] = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        req_valid[i] = 1'b1;
        req_data[i*16 +: 16] = 16'($urandom);
      end else begin
        req_valid[i] = 1'b0;
      end
    end
    rsp_ready = 4'($urandom_range(0, 15));
  endtask

  initial begin
    int g;
    int exp_order[5] = '{0, 1, 2, 3, 0};
    reset_in  = 1'b1;
    req_valid = 4'b0000;
    req_data  = 64'h0004_0003_0002_0001;
    rsp_ready = 4'b0000;
    modelReset();
    @(negedge clk);
    req_valid = 4'b1111;
    #1 checkOutput();
    chk("reset_req_ready", {28'd0, req_ready}, 32'h0);
    chk("reset_rsp_data", {16'd0, rsp_data}, 32'h0);
    @(negedge clk);
    reset_in = 1'b0;

    for (int j = 0; j < 5; j++) begin
      do_op(4'b1111, 0, g);
      chk("rr_order", g, exp_order[j]);
    end

    // Single request from requester 0 (ptr is 1, so the scan wraps).
    req_valid = 4'b0001;
    req_data[15:0] = 16'h0012;
    #1 checkOutput();
    chk("single_ready", {28'd0, req_ready}, 32'h1);
    applyStimulus();
    req_valid = 4'b0000;
`ifdef MLITE_ACC_ARB_CLEAR_EN
    #1 checkOutput();
    chk("single_clr", {31'd0, dp_clr}, 32'h1);
    chk("single_clr_noload", {31'd0, dp_load}, 32'h0);
    applyStimulus();
`endif
    #1 checkOutput();
    chk("single_load", {31'd0, dp_load}, 32'h1);
    chk("single_din", {16'd0, dp_din}, 32'h0012);
    applyStimulus();
    for (int k = 0; k < LAT; k++) begin
      #1 checkOutput();
      chk("single_wait_rv", {28'd0, rsp_valid}, 32'h0);
      applyStimulus();
    end
    // Response held five cycles; only requester 0's rsp_ready matters.
    req_valid = 4'b1111;
    rsp_ready = 4'b1110;
    for (int k = 0; k < 5; k++) begin
      #1 checkOutput();
      chk("hold_rsp_valid", {28'd0, rsp_valid}, 32'h1);
      chk("hold_rsp_data", {16'd0, rsp_data}, 32'h0113);
      chk("hold_no_ready", {28'd0, req_ready}, 32'h0);
      chk("hold_no_load", {31'd0, dp_load}, 32'h0);
      chk("hold_din_zero", {16'd0, dp_din}, 32'h0);
      applyStimulus();
    end
    rsp_ready = 4'b0001;
    #1 checkOutput();
    applyStimulus();
    rsp_ready = 4'b0000;
    #1 checkOutput();
    chk("after_single_ready", {28'd0, req_ready}, 32'h2);

    do_op(4'b0010, 0, g);
    chk("grant_1", g, 1);
    do_op(4'b0100, 0, g);
    chk("grant_2", g, 2);
    do_op(4'b0100, 0, g);
    chk("wrap_grant_2", g, 2);
    do_op(4'b1111, 3, g);
    chk("ptr_after_wrap", g, 3);
    do_op(4'b1111, 0, g);
    chk("grant_0_again", g, 0);

    // Reset in the middle of WAIT: outputs clear at once and scanning restarts at 0.
    req_valid = 4'b1111;
    #1 checkOutput();
    applyStimulus();
    for (int k = 0; k < 1 + C; k++) begin
      #1 checkOutput();
      applyStimulus();
    end
    #1 checkOutput();
    #1 reset_in = 1'b1;
    modelReset();
    #1;
    chk("rst_rsp_valid", {28'd0, rsp_valid}, 32'h0);
    chk("rst_dp_load", {31'd0, dp_load}, 32'h0);
    chk("rst_req_ready", {28'd0, req_ready}, 32'h0);
    checkOutput();
    @(posedge clk);
    @(negedge clk);
    reset_in = 1'b0;
    #1 checkOutput();
    chk("post_reset_grant", {28'd0, req_ready}, 32'h1);
    applyStimulus();

    for (int cyc = 0; cyc < 3000; cyc++) begin
      randomizeInputs();
      #1 checkOutput();
      applyStimulus();
      if (cyc % 997 == 500) pulseReset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
